// File: rtl/clkdiv_pkg.sv
// ----------------------------------------------------------------------------
// clkdiv_pkg
//   Shared types, defaults and helpers for the programmable clock divider.
//   CNT_W        : default half-period counter width (covers 25_000_000)
//   DEFAULT_HALF : default reset half-period (1 Hz output from a 50 MHz clk)
//   half_t       : half-period value at the default width
//   sat_half()   : maps a requested half-period of 0 to 1
//   ch_bits()    : width of a channel index, never less than 1 bit
// ----------------------------------------------------------------------------
package clkdiv_pkg;

    localparam int CNT_W        = 26;
    localparam int DEFAULT_HALF = 25_000_000;

    typedef logic [CNT_W-1:0] half_t;

    // A half-period of 0 cycles is meaningless; treat it as the fastest rate.
    function automatic half_t sat_half(input half_t v);
        return (v == '0) ? half_t'(1) : v;
    endfunction

    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : clkdiv_pkg

// File: rtl/clkdiv_channel.sv
// ----------------------------------------------------------------------------
// clkdiv_channel
//   One divider channel: half-period counter, active half-period, a single
//   pending reload slot and the registered divided clock / tick outputs.
//
//   Ports
//     clk         in   system clock
//     reset       in   asynchronous, active-high reset
//     en          in   run enable; low holds the counter and forces clk_out 0
//     restart     in   phase-align request: clear counter/output, apply load
//     cfg_accept  in   accepted config write addressed to this channel
//     cfg_half    in   requested half-period (0 is stored as 1)
//     clk_out     out  divided clock, 50% duty, period 2*H cycles
//     tick        out  one-cycle pulse on each 0->1 transition of clk_out
//     pending     out  a load is held and not yet applied
// ----------------------------------------------------------------------------
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W        = clkdiv_pkg::CNT_W,
    parameter int DEFAULT_HALF = clkdiv_pkg::DEFAULT_HALF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    input  logic             cfg_accept,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] RST_HALF =
        (DEFAULT_HALF < 1) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] pend_val;
    logic [CNT_W-1:0] load_val;
    logic             apply_next;
    logic             term;
    logic             do_apply;

    assign load_val = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    // '>=' rather than '==' so a half-period shortened while the counter is
    // already past the new terminal value still wraps on the next edge.
    assign term = (cnt >= half_q - CNT_W'(1));

    // A held load is applied whenever the counter restarts from zero anyway:
    // at terminal count, while disabled, on a restart, or one edge after an
    // accept that coincided with a restart.
    assign do_apply = pending & (restart | ~en | term | apply_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            half_q     <= RST_HALF;
            pend_val   <= RST_HALF;
            pending    <= 1'b0;
            apply_next <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            tick <= 1'b0;

            if (restart || !en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (term) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // NOTE: non-blocking assignments mean do_apply sees the pending
            // flag from before this edge, so an accept landing on a terminal
            // count is held until the following one instead of applying now.
            if (do_apply) begin
                half_q  <= pend_val;
                pending <= 1'b0;
            end

            apply_next <= restart & cfg_accept;

            // cfg_accept is only raised when pending is clear, so this never
            // collides with the apply above.
            if (cfg_accept) begin
                pend_val <= load_val;
                pending  <= 1'b1;
            end
        end
    end

endmodule : clkdiv_channel

// File: rtl/prog_clk_divider.sv
// ----------------------------------------------------------------------------
// prog_clk_divider
//   Multi-channel programmable clock divider producing 50%-duty divided
//   clock-enables and tick pulses. Each channel's half-period is loaded
//   through a valid/ready port and takes effect only at a half-period
//   boundary. clk_out is a fabric signal for enables/LEDs, not a clock net.
//
//   Optional build macro CLKDIV_SYNC_EN adds sync_restart, which clears every
//   channel's phase on the same edge and applies all pending loads.
//
//   Ports
//     clk           in   system clock
//     reset         in   asynchronous, active-high reset
//     ch_en         in   per-channel run enable
//     sync_restart  in   (CLKDIV_SYNC_EN only) phase-align all channels
//     cfg_valid     in   config request
//     cfg_ready     out  config accept; low only while the addressed channel
//                        already holds a pending load
//     cfg_ch        in   target channel; out-of-range requests are dropped
//     cfg_half      in   requested half-period in clk cycles
//     clk_out       out  divided clocks, registered
//     tick          out  one-cycle pulse on each 0->1 transition of clk_out
//     cfg_pending   out  load accepted but not yet applied
// ----------------------------------------------------------------------------
module prog_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = clkdiv_pkg::CNT_W,
    parameter int DEFAULT_HALF = clkdiv_pkg::DEFAULT_HALF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_en,
`ifdef CLKDIV_SYNC_EN
    input  logic                       sync_restart,
`endif
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [ch_bits(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]           cfg_half,
    output logic [NUM_CH-1:0]          clk_out,
    output logic [NUM_CH-1:0]          tick,
    output logic [NUM_CH-1:0]          cfg_pending
);

    localparam int CH_W  = ch_bits(NUM_CH);
    localparam int EXT_N = 1 << CH_W;

    logic              restart;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] cfg_accept;
    logic [EXT_N-1:0]  pend_ext;
    logic [EXT_N-1:0]  sel_ext;

`ifdef CLKDIV_SYNC_EN
    assign restart = sync_restart;
`else
    assign restart = 1'b0;
`endif

    // Pad the per-channel vectors to the full cfg_ch code space: indices past
    // NUM_CH read as "not pending" (ready) and select no channel, which drops
    // the request without any range comparison.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        pend_ext               = '0;
        pend_ext[NUM_CH-1:0]   = pending;
        sel_ext                = EXT_N'(1) << cfg_ch;
    end

    assign cfg_ready   = ~pend_ext[cfg_ch];
    assign cfg_accept  = {NUM_CH{cfg_valid & cfg_ready}} & sel_ext[NUM_CH-1:0];
    assign cfg_pending = pending;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .en         (ch_en[i]),
            .restart    (restart),
            .cfg_accept (cfg_accept[i]),
            .cfg_half   (cfg_half),
            .clk_out    (clk_out[i]),
            .tick       (tick[i]),
            .pending    (pending[i])
        );
    end

endmodule : prog_clk_divider

// File: tb/tb_prog_clk_divider.sv
// ----------------------------------------------------------------------------
// tb_prog_clk_divider
//   Directed bench for prog_clk_divider (default build) with DEFAULT_HALF=4.
//   Edge k is the k-th rising edge of a scenario; outputs are sampled 1 time
//   unit after it and next inputs are driven at the same point.
// ----------------------------------------------------------------------------
module tb_prog_clk_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] cfg_pending;

    int checks = 0;
    int errors = 0;

    // Expected per-edge bits, leftmost bit = edge 1.
    // Channel 1: H=3, reload 5 at edge 5, reload 2 at edge 17.
    logic [1:26] e1_clk  = 26'b00111_00000_11111_00000_11001_1;
    logic [1:26] e1_tick = 26'b00100_00000_10000_00000_10001_0;
    logic [1:26] e1_pend = 26'b00001_00000_00000_01111_00000_0;
    logic [1:26] e3_pend = 26'b00000_00000_00000_00010_00000_0;
    // Channel 3: H=6, enabled edges 1-8, disabled 9-10, re-enabled from 11.
    logic [1:16] e3_clk  = 16'b00000_111_00_00000_1;
    logic [1:16] e3_tick = 16'b00000_100_00_00000_1;
    // After reset with DEFAULT_HALF=4.
    logic [1:12] e_def   = 12'b0001_1110_0001;

    prog_clk_divider #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_en       (ch_en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_half    (cfg_half),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Load a disabled channel: pending for one cycle, then applied.
    task automatic load_disabled(input logic [1:0] ch, input logic [CNT_W-1:0] h);
        cfg_ch = ch; cfg_half = h; cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        check("dis_pend_set", 32'(cfg_pending[ch]), 32'd1);
        cyc();
        check("dis_pend_clr", 32'(cfg_pending[ch]), 32'd0);
    endtask

    // Channel 2 at H=1: clk_out toggles every edge, tick on odd edges.
    task automatic run_fast();
        ch_en[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check("fast_clk", 32'(clk_out[2]), 32'(k % 2));
            check("fast_tick", 32'(tick[2]), 32'(k % 2));
        end
        ch_en[2] = 1'b0;
        cyc();
        check("fast_off", 32'(clk_out[2]), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        ch_en     = 4'b0001;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_half  = '0;
        #12;
        check("rst_clk", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_pend", 32'(cfg_pending), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;

        // Default H=4: high on edges 4-7, low 8-11, tick at 4 and 12.
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("def_clk", 32'(clk_out[0]), 32'(e_def[k]));
            check("def_tick", 32'(tick[0]), 32'(k == 4 || k == 12));
        end

        // Half-period 0 saturates to 1, same behaviour as 1.
        load_disabled(2'd2, 8'd0);
        run_fast();
        load_disabled(2'd2, 8'd1);
        run_fast();

        // Channel 1 at H=3, mid-period reloads, busy/other-channel handshake.
        load_disabled(2'd1, 8'd3);
        ch_en[1] = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            cfg_valid = 1'b0;
            if (k == 5)  begin cfg_ch = 2'd1; cfg_half = 8'd5; cfg_valid = 1'b1; end
            if (k == 17) begin cfg_ch = 2'd1; cfg_half = 8'd2; cfg_valid = 1'b1; end
            if (k == 18) begin
                cfg_ch = 2'd1; cfg_half = 8'd7; cfg_valid = 1'b1;
                #1 check("busy_ready", 32'(cfg_ready), 32'd0);
            end
            if (k == 19) begin
                cfg_ch = 2'd3; cfg_half = 8'd6; cfg_valid = 1'b1;
                #1 check("other_ready", 32'(cfg_ready), 32'd1);
            end
            cyc();
            check("ch1_clk", 32'(clk_out[1]), 32'(e1_clk[k]));
            check("ch1_tick", 32'(tick[1]), 32'(e1_tick[k]));
            check("ch1_pend", 32'(cfg_pending[1]), 32'(e1_pend[k]));
            check("ch3_pend", 32'(cfg_pending[3]), 32'(e3_pend[k]));
        end
        cfg_valid = 1'b0;

        // Channel 3 at H=6: drop enable while high, re-raise, first tick H later.
        // A load to channel 1 is accepted on the last edge to leave it pending.
        ch_en[3] = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            cfg_valid = 1'b0;
            if (j == 9)  ch_en[3] = 1'b0;
            if (j == 11) ch_en[3] = 1'b1;
            if (j == 16) begin cfg_ch = 2'd1; cfg_half = 8'd9; cfg_valid = 1'b1; end
            cyc();
            check("ch3_clk", 32'(clk_out[3]), 32'(e3_clk[j]));
            check("ch3_tick", 32'(tick[3]), 32'(e3_tick[j]));
        end
        cfg_valid = 1'b0;
        cfg_ch    = 2'd1;
        check("pre_rst_pend", 32'(cfg_pending[1]), 32'd1);

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        #3 reset = 1'b1;
        #1;
        check("arst_clk", 32'(clk_out), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_pend", 32'(cfg_pending), 32'd0);
        check("arst_ready", 32'(cfg_ready), 32'd1);
        #2 reset = 1'b0;

        // All enabled channels (0, 1, 3) are back at H=4 and phase-aligned.
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("post_rst_clk", 32'(clk_out), e_def[k] ? 32'd11 : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_prog_clk_divider
